// File: rtl/sort_stream_pkg.sv
// Shared types and constants for the sorted-vector output streamer.
package sort_stream_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_NBUF   = 2;
    localparam int DROP_CNT_W = 8;

    typedef logic [DEF_WIDTH-1:0] elem_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/sort_result_streamer_vec_buffer.sv
// NBUF-slot FIFO of whole sorted vectors; a pop in the same cycle frees a slot for a push.
module vec_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int NBUF  = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic                              pop,
    input  logic [DEPTH-1:0][WIDTH-1:0]       din,
    output logic                              free,
    output logic [DEPTH-1:0][WIDTH-1:0]       head_vec,
    output logic [$clog2(NBUF+1)-1:0]         count,
    output logic                              full
);

    localparam int PTR_W = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int CNT_W = $clog2(NBUF+1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q [NBUF];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             accept;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NBUF-1)) ? '0 : p + 1'b1;
    endfunction

    assign free   = (count_q != CNT_W'(NBUF)) || pop;
    assign accept = push && free;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_W'(NBUF));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset: slots are only read once counted as occupied.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= din;
    end

    assign head_vec = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = full_q;

endmodule

// File: rtl/sort_result_streamer.sv
// Captures sorter output vectors and streams them one element per valid/ready beat.
// Optional sortedness checker (order_err output) enabled by defining SORT_CHECK_EN.
module sort_result_streamer
    import sort_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int NBUF  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    input  logic [DEPTH-1:0][WIDTH-1:0]   sorted_in,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WIDTH-1:0]              m_data,
    output logic [$clog2(DEPTH)-1:0]      m_index,
    output logic                          m_last,
    output logic                          full,
`ifdef SORT_CHECK_EN
    output logic                          order_err,
`endif
    output logic                          overflow,
    output logic [DROP_CNT_W-1:0]         drop_cnt
);

    // m_valid/m_ready: an element transfers on any rising edge where both are high;
    // once m_valid rises, m_data/m_index/m_last hold until that transfer happens.

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(NBUF+1);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            elem_idx_q, elem_idx_d;
    logic                        overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]       drop_cnt_q, drop_cnt_d;

    logic                        free;
    logic [DEPTH-1:0][WIDTH-1:0] head_vec;
    logic [CNT_W-1:0]            count;
    logic                        buf_full;
    logic                        accept;
    logic                        drop;
    logic                        hs;
    logic                        pop;

    vec_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NBUF  (NBUF)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (valid_in),
        .pop      (pop),
        .din      (sorted_in),
        .free     (free),
        .head_vec (head_vec),
        .count    (count),
        .full     (buf_full)
    );

    assign m_valid = (state_q == STREAM);
    assign m_index = elem_idx_q;
    assign m_last  = m_valid && (elem_idx_q == IDX_W'(DEPTH-1));
    assign m_data  = m_valid ? head_vec[elem_idx_q] : '0;
    assign full    = buf_full;

    assign hs     = m_valid && m_ready;
    assign pop    = hs && m_last;
    assign accept = valid_in && free;
    assign drop   = valid_in && !free;

    always_comb begin
        state_d    = state_q;
        elem_idx_d = elem_idx_q;
        case (state_q)
            IDLE: begin
                if (count != '0) state_d = STREAM;
            end
            STREAM: begin
                if (hs) begin
                    if (m_last) begin
                        elem_idx_d = '0;
                        // Post-release occupancy is zero only if this was the last vector and nothing arrives.
                        if (count == CNT_W'(1) && !accept) state_d = IDLE;
                    end else begin
                        elem_idx_d = elem_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q || drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            elem_idx_q <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            elem_idx_q <= elem_idx_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

`ifdef SORT_CHECK_EN
    logic order_err_q, order_err_d;
    logic unsorted;

    always_comb begin
        unsorted = 1'b0;
        for (int i = 0; i < DEPTH-1; i++) begin
            if (sorted_in[i] > sorted_in[i+1]) unsorted = 1'b1;
        end
        order_err_d = order_err_q || (accept && unsorted);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) order_err_q <= 1'b0;
        else        order_err_q <= order_err_d;
    end

    assign order_err = order_err_q;
`endif

endmodule

// File: tb/tb_sort_result_streamer.sv
// Directed self-checking bench for sort_result_streamer (WIDTH=32, DEPTH=8, NBUF=2).
module tb_sort_result_streamer;

  localparam int W    = 32;
  localparam int D    = 8;
  localparam int NB   = 2;
  localparam int EW   = W + 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid_in = 1'b0;
  logic [D-1:0][W-1:0]  sorted_in = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [W-1:0]         m_data;
  logic [2:0]           m_index;
  logic                 m_last;
  logic                 full;
  logic                 overflow;
  logic [7:0]           drop_cnt;
`ifdef SORT_CHECK_EN
  logic                 order_err;
`endif

  sort_result_streamer #(.WIDTH(W), .DEPTH(D), .NBUF(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .sorted_in (sorted_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_index   (m_index),
    .m_last    (m_last),
    .full      (full),
`ifdef SORT_CHECK_EN
    .order_err (order_err),
`endif
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic          mon_en = 1'b0;
  logic          stall_q = 1'b0;
  logic [W-1:0]  held_data;
  logic [2:0]    held_idx;
  int            cyc = 0;
  int            beats = 0;
  int            first_cyc = -1;
  int            last_cyc = -1;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    cyc++;
    if (mon_en && rst_n) begin
      if (stall_q) begin
        check("hold_valid", W'(m_valid), 1);
        check("hold_data", m_data, held_data);
        check("hold_index", W'(m_index), W'(held_idx));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", W'(m_data), '1);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e[W-1:0]);
          check("beat_index", W'(m_index), W'(e[EW-1:W]));
          check("beat_last", W'(m_last), W'(e[EW-1:W] == 3'd7));
          beats++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
      stall_q   = m_valid && !m_ready;
      held_data = m_data;
      held_idx  = m_index;
    end else begin
      stall_q = 1'b0;
    end
  end

  // driver tasks
  function automatic logic [D-1:0][W-1:0] mk(input int unsigned a0, a1, a2, a3, a4, a5, a6, a7);
    logic [D-1:0][W-1:0] v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
    return v;
  endfunction

  task automatic expect_vec(input logic [D-1:0][W-1:0] v);
    for (int i = 0; i < D; i++) exp_q.push_back({3'(i), v[i]});
  endtask

  task automatic send_vec(input logic [D-1:0][W-1:0] v, input bit keep);
    @(posedge clk); #1;
    sorted_in = v;
    valid_in  = 1'b1;
    if (keep) expect_vec(v);
    @(posedge clk); #1;
    valid_in  = 1'b0;
  endtask

  task automatic clear_stats();
    beats = 0;
    first_cyc = -1;
    last_cyc = -1;
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    m_ready  = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    clear_stats();
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk); #1;
      if (!m_valid && exp_q.size() == 0) done = 1;
    end
    check(tag, W'(done), 1);
  endtask

  logic [D-1:0][W-1:0] va, vb, vc;
  logic                tog_en = 1'b0;
  logic [3:0]          pat = 4'b1001;

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    check("rst_m_valid", W'(m_valid), 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_index", W'(m_index), 0);
    check("rst_m_last", W'(m_last), 0);
    check("rst_full", W'(full), 0);
    check("rst_overflow", W'(overflow), 0);
    check("rst_drop_cnt", W'(drop_cnt), 0);

    // single vector with first-beat latency
    va = mk(1, 2, 3, 5, 7, 10, 18, 25);
    m_ready = 1'b1;
    send_vec(va, 1);
    @(negedge clk);
    check("lat_not_yet", W'(m_valid), 0);
    @(negedge clk);
    check("lat_valid", W'(m_valid), 1);
    check("lat_elem0", m_data, 1);
    check("lat_index0", W'(m_index), 0);
    wait_idle("single_drain");
    check("single_beats", W'(beats), 8);
    check("single_span", W'(last_cyc - first_cyc), 7);

    // backpressure with ready pattern 1,0,0,1
    do_reset();
    tog_en = 1'b1;
    fork
      begin
        int k = 0;
        while (tog_en) begin
          @(posedge clk); #1;
          m_ready = pat[k % 4];
          k++;
        end
      end
    join_none
    send_vec(va, 1);
    wait_idle("bp_drain");
    tog_en = 1'b0;
    repeat (2) @(posedge clk);
    check("bp_beats", W'(beats), 8);

    // back-to-back vectors, no bubble
    do_reset();
    m_ready = 1'b1;
    va = mk(1, 2, 3, 4, 5, 6, 7, 8);
    vb = mk(0, 1, 5, 10, 25, 50, 75, 100);
    send_vec(va, 1);
    send_vec(vb, 1);
    wait_idle("b2b_drain");
    check("b2b_beats", W'(beats), 16);
    check("b2b_no_gap", W'(last_cyc - first_cyc), 15);

    // overflow: third vector dropped while stalled
    do_reset();
    va = mk(11, 12, 13, 14, 15, 16, 17, 18);
    vb = mk(21, 22, 23, 24, 25, 26, 27, 28);
    vc = mk(31, 32, 33, 34, 35, 36, 37, 38);
    send_vec(va, 1);
    @(negedge clk);
    check("ovf_full_after1", W'(full), 0);
    send_vec(vb, 1);
    @(negedge clk);
    check("ovf_full_after2", W'(full), 1);
    check("ovf_no_flag_yet", W'(overflow), 0);
    send_vec(vc, 0);
    @(negedge clk);
    check("ovf_flag", W'(overflow), 1);
    check("ovf_drop_cnt", W'(drop_cnt), 1);
    check("ovf_still_full", W'(full), 1);
    m_ready = 1'b1;
    wait_idle("ovf_drain");
    check("ovf_beats", W'(beats), 16);
    check("ovf_full_cleared", W'(full), 0);

    // simultaneous release at m_last and capture at full
    do_reset();
    send_vec(va, 1);
    send_vec(vb, 1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (m_valid && m_last) seen = 1;
      end
      check("sim_reach_last", W'(seen), 1);
    end
    sorted_in = vc;
    valid_in  = 1'b1;
    expect_vec(vc);
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    check("sim_full_kept", W'(full), 1);
    check("sim_no_drop", W'(drop_cnt), 0);
    check("sim_no_overflow", W'(overflow), 0);
    wait_idle("sim_drain");
    check("sim_beats", W'(beats), 24);
    check("sim_no_gap", W'(last_cyc - first_cyc), 23);

    // asynchronous reset mid-stream
    do_reset();
    m_ready = 1'b1;
    send_vec(va, 1);
    begin
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (m_valid && m_index == 3'd3) seen = 1;
      end
      check("rst_mid_reach", W'(seen), 1);
    end
    mon_en = 1'b0;
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    check("rstm_m_valid", W'(m_valid), 0);
    check("rstm_m_data", m_data, 0);
    check("rstm_m_index", W'(m_index), 0);
    check("rstm_m_last", W'(m_last), 0);
    check("rstm_full", W'(full), 0);
    check("rstm_overflow", W'(overflow), 0);
    check("rstm_drop_cnt", W'(drop_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    clear_stats();
    vc = mk(9, 9, 9, 9, 9, 9, 9, 9);
    send_vec(vc, 1);
    wait_idle("rstm_drain");
    check("rstm_beats", W'(beats), 8);

`ifdef SORT_CHECK_EN
    check("order_err_clean", W'(order_err), 0);
    vc = mk(2, 1, 3, 4, 5, 6, 7, 8);
    send_vec(vc, 1);
    @(negedge clk);
    check("order_err_set", W'(order_err), 1);
    wait_idle("order_drain");
    check("order_err_sticky", W'(order_err), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sort_result_streamer.md
Name: sort_result_streamer

Overview:
Output-side adapter for the bitonic sorter top. Captures each parallel sorted vector on the sorter's valid_out pulse. Buffers up to NBUF vectors, then streams them one element per handshake on a valid/ready interface, lowest index first. Vectors that arrive while the buffer is full are dropped and flagged, because the sorter has no backpressure.

Parameters:
WIDTH, 32, bits per element
DEPTH, 8, elements per vector; power of two, >=2
NBUF, 2, vector buffer slots; power of two, >=1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
valid_in  in  1  one-cycle capture strobe, driven by sorter valid_out
sorted_in  in  WIDTH x DEPTH  parallel sorted vector, element 0 = smallest
m_valid  out  1  element available
m_ready  in  1  downstream accepts element
m_data  out  WIDTH  current element
m_index  out  $clog2(DEPTH)  index of m_data within its vector
m_last  out  1  high with element DEPTH-1
full  out  1  all NBUF slots occupied
overflow  out  1  sticky; a vector was dropped
drop_cnt  out  8  count of dropped vectors, saturates at 255

Behaviour:
- Reset: the asynchronous assert of rst_n clears all outputs to 0. It also clears wr_ptr, rd_ptr, count and elem_idx, and puts the FSM in IDLE. Buffer contents are don't-care.
- Capture: on a clk edge with valid_in=1 and a free slot, sorted_in is written to slot wr_ptr, then wr_ptr+1 (wrap mod NBUF) and count+1.
- Slot-free rule: a slot counts as free when count<NBUF, or when this same cycle completes the final handshake of the head vector (m_valid & m_ready & m_last). A simultaneous capture and release at full is legal; count stays unchanged.
- Drop: valid_in=1 with no free slot leaves the buffer untouched. overflow is set to 1 and drop_cnt increments, saturating at 255.
- FSM states:
  - IDLE: m_valid=0. Go to STREAM when count becomes nonzero.
  - STREAM: m_valid=1; m_data = slot[rd_ptr][elem_idx]; m_index = elem_idx; m_last = (elem_idx==DEPTH-1).
- Handshake (STREAM): on m_valid & m_ready, elem_idx+1.
  - If m_last, elem_idx returns to 0, rd_ptr+1 (wrap) and count-1.
  - After a release, stay in STREAM if the post-update count is nonzero, else go to IDLE.
- Latency: a capture at edge N gives m_valid=1 after edge N+1, presenting element 0, when the buffer was empty. Back-to-back vectors stream with no bubble between m_last and the next element 0.
- Output stability: while m_valid=1 and m_ready=0, m_data, m_index and m_last hold stable. m_valid never deasserts without a handshake.
- Registers: m_data is taken from registered buffer storage; there is no combinational path from m_ready to m_valid.
- full = (count==NBUF), registered.
- Reset mid-stream: the partially streamed vector and all buffered vectors are discarded. After release the block resumes in IDLE.

Optional Feature:
- Macro: SORT_CHECK_EN.
- Defined: adds output order_err (1 bit, sticky, reset 0). At capture it is set if any sorted_in[i] > sorted_in[i+1] (unsigned compare). The vector is still stored and streamed unchanged.
- Undefined: port and comparator logic are absent; the interface is otherwise identical.

Decomposition:
- Package sort_stream_pkg holds:
  - state enum {IDLE, STREAM};
  - typedef elem_t = logic [WIDTH-1:0] with default widths;
  - constant DROP_CNT_W = 8.
- One sub-module: vec_buffer, an NBUF-slot, DEPTH-wide register-file FIFO. It owns wr_ptr, rd_ptr and count, and exposes push, pop, free and head_vec.
- The streamer FSM, element counter and overflow logic stay in the top.

Test Plan:
- Single vector: after reset, valid_in pulse with {1,2,3,5,7,10,18,25}, m_ready=1 held. Expect m_valid on the next cycle, then 8 consecutive beats 1..25 with m_index 0..7 and m_last only on value 25, then m_valid=0.
- Backpressure: the same vector with m_ready toggling 1,0,0,1 repeating. Each element is held stable while stalled, the order is unchanged, and no beat is duplicated or skipped.
- Back-to-back: vectors {1..8} and {0,1,5,10,25,50,75,100} captured 2 cycles apart, m_ready=1. Expect 16 beats with no gap; value 8 (m_last) is followed directly by 0 (m_index 0).
- Overflow: NBUF=2, m_ready=0, three valid_in pulses. Expect full=1 after the second pulse; the third is dropped, overflow=1 and drop_cnt=1. Releasing m_ready streams exactly vectors 1 and 2.
- Simultaneous release and capture: buffer full and head at m_last with m_ready=1, valid_in pulse on the same edge. Expect no drop, count stays 2, and the new vector is streamed last.
- Reset mid-stream: assert rst_n=0 asynchronously between clock edges during beat 3 of a vector. Expect all outputs to be 0 immediately. After release a new vector {9,9,9,9,9,9,9,9} streams from m_index 0. With SORT_CHECK_EN, capturing {2,1,3,4,5,6,7,8} sets order_err=1.
